p405s_icu_dataarray_arb: RTL and testbench

- Arbiter and sequencer for the 512x128 ICU data array, way B.
- Shares the single-port array between instruction-fetch reads and line-fill quadword writes.
- Fill writes pass through a small posted write buffer, so the fill path rarely stalls.
- Fetch has priority, bounded by a starvation limit and a read-after-write hazard check; the block also idles the array while RAM BIST owns it.

---
 rtl/p405s_icu_dataarray_arb.sv | 175 +++++++++++++++++
 tb/tb_p405s_icu_dataarray_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_icu_dataarray_arb.sv
// ICU data array (way B) arbiter: fetch reads vs. posted line-fill writes.
// Fetch wins unless a buffered write hazards it or reads have starved writes.
module p405s_icu_dataarray_arb #(
  parameter int WBUF_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         CB,
  input  logic         resetCore,
  input  logic         fetchReq,
  input  logic [9:0]   fetchIndex,
  output logic         fetchGnt,
  output logic         fetchDataVal,
  output logic [127:0] fetchData,
  input  logic         fillReq,
  input  logic [9:0]   fillIndex,
  input  logic [127:0] fillData,
  input  logic [15:0]  fillByteEn,
  output logic         fillAck,
  output logic         wbufEmpty,
  input  logic         bistMode,
  output logic         cycleDataRamB,
  output logic         readWrB,
  output logic [9:0]   dataIndexB,
  output logic [15:0]  byteWrite,
  output logic [127:0] dataIn,
  input  logic [127:0] ramDataOut
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BIST    = 2'd1,
    RECOVER = 2'd2
  } mode_e;

  mode_e r_mode;
  mode_e w_modeNxt;

  logic [9:0]            r_qIdx  [WBUF_DEPTH];
  logic [127:0]          r_qData [WBUF_DEPTH];
  logic [15:0]           r_qBe   [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] r_qVld;
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_cnt;
  logic [SW-1:0]         r_starve;

  logic         r_cyc;
  logic         r_rw;
  logic [9:0]   r_aIdx;
  logic [15:0]  r_bw;
  logic [127:0] r_din;
  logic         r_dv;

  logic w_run;
  logic w_empty;
  logic w_full;
  logic w_hit;
  logic w_hazard;
  logic w_starved;
  logic w_writeSel;
  logic w_readSel;
  logic w_push;

  assign w_run     = (r_mode == RUN);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(WBUF_DEPTH));
  assign w_starved = (r_starve == SW'(STARVE_LIMIT));

  // Array word address is index[9:1]; index[0] never aliases a new row.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (r_qVld[i] && (r_qIdx[i][9:1] == fetchIndex[9:1])) begin
        w_hit = 1'b1;
      end
    end
  end

  assign w_hazard   = fetchReq & w_hit;
  assign w_writeSel = w_run & ~w_empty &
                      (~fetchReq | w_hazard | w_starved);
  assign w_readSel  = w_run & fetchReq & ~w_writeSel;
  assign w_push     = w_run & fillReq & ~w_full;

  assign fetchGnt      = w_readSel;
  assign fillAck       = w_push;
  assign wbufEmpty     = w_empty;
  assign fetchData     = ramDataOut;
  assign fetchDataVal  = r_dv;
  assign cycleDataRamB = r_cyc;
  assign readWrB       = r_rw;
  assign dataIndexB    = r_aIdx;
  assign byteWrite     = r_bw;
  assign dataIn        = r_din;

  always_comb begin
    w_modeNxt = r_mode;
    unique case (r_mode)
      RUN:     if (bistMode)  w_modeNxt = BIST;
      BIST:    if (!bistMode) w_modeNxt = RECOVER;
      RECOVER: w_modeNxt = RUN;
      default: w_modeNxt = RUN;
    endcase
  end

  always_ff @(posedge CB) begin
    if (w_push) begin
      r_qIdx[r_wp]  <= fillIndex;
      r_qData[r_wp] <= fillData;
      r_qBe[r_wp]   <= fillByteEn;
    end
  end

  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      r_mode   <= RUN;
      r_qVld   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
    end else begin
      r_mode <= w_modeNxt;
      if (w_push) begin
        r_qVld[r_wp] <= 1'b1;
        r_wp         <= r_wp + PW'(1);
      end
      if (w_writeSel) begin
        r_qVld[r_rp] <= 1'b0;
        r_rp         <= r_rp + PW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_writeSel);
      if (w_run) begin
        if (w_writeSel || w_empty) begin
          r_starve <= '0;
        end else if (w_readSel && !w_starved) begin
          r_starve <= r_starve + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      r_cyc  <= 1'b0;
      r_rw   <= 1'b1;
      r_aIdx <= '0;
      r_bw   <= '0;
      r_din  <= '0;
      r_dv   <= 1'b0;
    end else begin
      r_dv  <= r_cyc & r_rw;
      r_cyc <= w_readSel | w_writeSel;
      r_rw  <= ~w_writeSel;
      if (w_writeSel) begin
        r_aIdx <= r_qIdx[r_rp];
        r_bw   <= r_qBe[r_rp];
        r_din  <= r_qData[r_rp];
      end else if (w_readSel) begin
        r_aIdx <= fetchIndex;
        r_bw   <= '0;
        r_din  <= '0;
      end else begin
        r_aIdx <= '0;
        r_bw   <= '0;
        r_din  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_p405s_icu_dataarray_arb.sv
// Directed bench for the ICU data array arbiter with a behavioural SRAM.
// Each table row is one cycle: inputs plus the outputs expected in that cycle.
module tb_p405s_icu_dataarray_arb;

  logic         CB = 1'b0;
  logic         resetCore = 1'b1;
  logic         fetchReq = 1'b0;
  logic [9:0]   fetchIndex = '0;
  logic         fetchGnt;
  logic         fetchDataVal;
  logic [127:0] fetchData;
  logic         fillReq = 1'b0;
  logic [9:0]   fillIndex = '0;
  logic [127:0] fillData = '0;
  logic [15:0]  fillByteEn = 16'hFFFF;
  logic         fillAck;
  logic         wbufEmpty;
  logic         bistMode = 1'b0;
  logic         cycleDataRamB;
  logic         readWrB;
  logic [9:0]   dataIndexB;
  logic [15:0]  byteWrite;
  logic [127:0] dataIn;
  logic [127:0] ramDataOut = '0;

  int checks = 0;
  int failures = 0;

  always #5 CB = ~CB;

  p405s_icu_dataarray_arb #(.WBUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .CB(CB), .resetCore(resetCore),
    .fetchReq(fetchReq), .fetchIndex(fetchIndex),
    .fetchGnt(fetchGnt), .fetchDataVal(fetchDataVal),
    .fetchData(fetchData),
    .fillReq(fillReq), .fillIndex(fillIndex),
    .fillData(fillData), .fillByteEn(fillByteEn),
    .fillAck(fillAck), .wbufEmpty(wbufEmpty),
    .bistMode(bistMode),
    .cycleDataRamB(cycleDataRamB), .readWrB(readWrB),
    .dataIndexB(dataIndexB), .byteWrite(byteWrite),
    .dataIn(dataIn), .ramDataOut(ramDataOut)
  );

  function automatic logic [127:0] pp(input logic [8:0] a);
    return {4{23'h5A5A5, a}};
  endfunction

  function automatic logic [127:0] dp(input logic [9:0] i);
    return {4{22'h2BEEF, i}};
  endfunction

  logic [127:0] mem [512];

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = pp(9'(a));
  end

  always @(posedge CB) begin
    if (cycleDataRamB) begin
      if (readWrB) begin
        ramDataOut <= mem[dataIndexB[9:1]];
      end else begin
        for (int b = 0; b < 16; b++) begin
          if (byteWrite[b]) mem[dataIndexB[9:1]][8*b +: 8] <= dataIn[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    logic         fr;
    logic [9:0]   fi;
    logic         wr;
    logic [9:0]   wi;
    logic         bi;
    logic         gnt;
    logic         ack;
    logic         emp;
    logic         cyc;
    logic         rw;
    logic [9:0]   aidx;
    logic         dv;
    logic [127:0] dat;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic fr, input logic [9:0] fi,
                   input logic wr, input logic [9:0] wi, input logic bi,
                   input logic gnt, input logic ack, input logic emp,
                   input logic cyc, input logic rw, input logic [9:0] aidx,
                   input logic dv, input logic [127:0] dat);
    vec_t r;
    r.fr = fr; r.fi = fi; r.wr = wr; r.wi = wi; r.bi = bi;
    r.gnt = gnt; r.ack = ack; r.emp = emp; r.cyc = cyc; r.rw = rw;
    r.aidx = aidx; r.dv = dv; r.dat = dat;
    vq.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cyc"}, 128'(cycleDataRamB), 128'(0));
    chk({tag, "_rw"}, 128'(readWrB), 128'(1));
    chk({tag, "_idx"}, 128'(dataIndexB), 128'(0));
    chk({tag, "_bw"}, 128'(byteWrite), 128'(0));
    chk({tag, "_din"}, dataIn, 128'(0));
    chk({tag, "_dv"}, 128'(fetchDataVal), 128'(0));
    chk({tag, "_gnt"}, 128'(fetchGnt), 128'(0));
    chk({tag, "_ack"}, 128'(fillAck), 128'(0));
    chk({tag, "_emp"}, 128'(wbufEmpty), 128'(1));
  endtask

  task automatic drive(input logic fr, input logic [9:0] fi,
                       input logic wr, input logic [9:0] wi,
                       input logic bi);
    fetchReq = fr; fetchIndex = fi;
    fillReq = wr; fillIndex = wi; fillData = dp(wi);
    bistMode = bi;
  endtask

  initial begin
    // fills under read pressure, then third fill against a full buffer
    v(1,10'h100,1,10'h010,0, 1,1,1,0,1,10'h000,0,'0);
    v(1,10'h102,1,10'h011,0, 1,1,0,1,1,10'h100,0,'0);
    v(1,10'h104,1,10'h012,0, 1,0,0,1,1,10'h102,1,pp(9'h080));
    v(1,10'h106,1,10'h012,0, 1,0,0,1,1,10'h104,1,pp(9'h081));
    v(1,10'h108,1,10'h012,0, 1,0,0,1,1,10'h106,1,pp(9'h082));
    v(1,10'h10A,1,10'h012,0, 0,0,0,1,1,10'h108,1,pp(9'h083));
    v(1,10'h10A,1,10'h012,0, 1,1,0,1,0,10'h010,1,pp(9'h084));
    v(0,10'h000,0,10'h000,0, 0,0,0,1,1,10'h10A,0,'0);
    v(0,10'h000,0,10'h000,0, 0,0,0,1,0,10'h011,1,pp(9'h085));
    v(0,10'h000,0,10'h000,0, 0,0,1,1,0,10'h012,0,'0);
    v(0,10'h000,0,10'h000,0, 0,0,1,0,1,10'h000,0,'0);
    // fetch from idle
    v(1,10'h040,0,10'h000,0, 1,0,1,0,1,10'h000,0,'0);
    v(0,10'h000,0,10'h000,0, 0,0,1,1,1,10'h040,0,'0);
    v(0,10'h000,0,10'h000,0, 0,0,1,0,1,10'h000,1,pp(9'h020));
    // read-after-write hazard
    v(0,10'h000,1,10'h020,0, 0,1,1,0,1,10'h000,0,'0);
    v(1,10'h020,0,10'h000,0, 0,0,0,0,1,10'h000,0,'0);
    v(1,10'h020,0,10'h000,0, 1,0,1,1,0,10'h020,0,'0);
    v(0,10'h000,0,10'h000,0, 0,0,1,1,1,10'h020,0,'0);
    v(0,10'h000,0,10'h000,0, 0,0,1,0,1,10'h000,1,dp(10'h020));
    // starvation limit with one buffered write
    v(0,10'h000,1,10'h030,0, 0,1,1,0,1,10'h000,0,'0);
    v(1,10'h200,0,10'h000,0, 1,0,0,0,1,10'h000,0,'0);
    v(1,10'h202,0,10'h000,0, 1,0,0,1,1,10'h200,0,'0);
    v(1,10'h204,0,10'h000,0, 1,0,0,1,1,10'h202,1,pp(9'h100));
    v(1,10'h206,0,10'h000,0, 1,0,0,1,1,10'h204,1,pp(9'h101));
    v(1,10'h208,0,10'h000,0, 0,0,0,1,1,10'h206,1,pp(9'h102));
    v(1,10'h208,0,10'h000,0, 1,0,1,1,0,10'h030,1,pp(9'h103));
    v(0,10'h000,0,10'h000,0, 0,0,1,1,1,10'h208,0,'0);
    v(0,10'h000,0,10'h000,0, 0,0,1,0,1,10'h000,1,pp(9'h104));
    // BIST window with two buffered entries and fetch pending
    v(0,10'h000,1,10'h050,0, 0,1,1,0,1,10'h000,0,'0);
    v(1,10'h300,1,10'h051,0, 1,1,0,0,1,10'h000,0,'0);
    v(1,10'h302,1,10'h052,1, 1,0,0,1,1,10'h300,0,'0);
    v(1,10'h304,1,10'h052,1, 0,0,0,1,1,10'h302,1,pp(9'h180));
    v(1,10'h304,1,10'h052,1, 0,0,0,0,1,10'h000,1,pp(9'h181));
    v(1,10'h304,1,10'h052,1, 0,0,0,0,1,10'h000,0,'0);
    v(1,10'h304,1,10'h052,1, 0,0,0,0,1,10'h000,0,'0);
    v(1,10'h304,1,10'h052,0, 0,0,0,0,1,10'h000,0,'0);
    v(1,10'h304,1,10'h052,0, 0,0,0,0,1,10'h000,0,'0);
    v(1,10'h304,1,10'h052,0, 1,0,0,0,1,10'h000,0,'0);
    v(1,10'h306,1,10'h052,0, 1,0,0,1,1,10'h304,0,'0);
    v(1,10'h308,1,10'h052,0, 0,0,0,1,1,10'h306,1,pp(9'h182));
    v(1,10'h308,1,10'h052,0, 1,1,0,1,0,10'h050,1,pp(9'h183));
    v(0,10'h000,0,10'h000,0, 0,0,0,1,1,10'h308,0,'0);
    v(0,10'h000,0,10'h000,0, 0,0,0,1,0,10'h051,1,pp(9'h184));
    v(0,10'h000,0,10'h000,0, 0,0,1,1,0,10'h052,0,'0);
    v(0,10'h000,0,10'h000,0, 0,0,1,0,1,10'h000,0,'0);

    repeat (2) @(negedge CB);
    #2 chk_reset("por");
    @(negedge CB);
    resetCore = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      string t;
      vec_t r;
      logic [15:0]  ebw;
      logic [127:0] edin;
      r = vq[k];
      @(negedge CB);
      drive(r.fr, r.fi, r.wr, r.wi, r.bi);
      #2;
      t = $sformatf("row%0d", k + 1);
      ebw  = (r.cyc && !r.rw) ? 16'hFFFF : 16'h0000;
      edin = (r.cyc && !r.rw) ? dp(r.aidx) : 128'h0;
      chk({t, "_gnt"}, 128'(fetchGnt), 128'(r.gnt));
      chk({t, "_ack"}, 128'(fillAck), 128'(r.ack));
      chk({t, "_emp"}, 128'(wbufEmpty), 128'(r.emp));
      chk({t, "_cyc"}, 128'(cycleDataRamB), 128'(r.cyc));
      chk({t, "_rw"}, 128'(readWrB), 128'(r.rw));
      chk({t, "_dv"}, 128'(fetchDataVal), 128'(r.dv));
      if (r.cyc) begin
        chk({t, "_idx"}, 128'(dataIndexB), 128'(r.aidx));
        chk({t, "_bw"}, 128'(byteWrite), 128'(ebw));
        chk({t, "_din"}, dataIn, edin);
      end
      if (r.dv) chk({t, "_data"}, fetchData, r.dat);
    end

    // asynchronous reset while the buffer is full and a read is in flight
    @(negedge CB);
    drive(1, 10'h400, 1, 10'h060, 0);
    @(negedge CB);
    drive(1, 10'h402, 1, 10'h061, 0);
    @(negedge CB);
    drive(1, 10'h404, 1, 10'h062, 0);
    #2;
    chk("pre_rst_cyc", 128'(cycleDataRamB), 128'(1));
    chk("pre_rst_emp", 128'(wbufEmpty), 128'(0));
    chk("pre_rst_ack", 128'(fillAck), 128'(0));
    drive(0, 10'h000, 0, 10'h000, 0);
    resetCore = 1'b1;
    #1 chk_reset("async");
    @(negedge CB);
    resetCore = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CB);
      #2;
      chk($sformatf("post%0d_cyc", c), 128'(cycleDataRamB), 128'(0));
      chk($sformatf("post%0d_emp", c), 128'(wbufEmpty), 128'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
